// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared opcodes, multiplier FSM states and constants for the EX stage
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MFHI  = 4'd11;
  localparam logic [3:0] ALU_PASSB = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam int MUL_ITER = 16;

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode-to-EX inputs and EX-to-memory outputs of the execute stage
interface execute_stage_if #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
);
  logic             valid_in;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] store_data_in;
  logic             mem_en_in;
  logic             mem_rw_in;
  logic             mem_mux_sel_in;
  logic             reg_wr_in;
  logic [RA_W-1:0]  rd_in;

  logic             stall_out;
  logic [WIDTH-1:0] ans_ex;
  logic [WIDTH-1:0] DM_data;
  logic             mem_en_ex;
  logic             mem_rw_ex;
  logic             mem_mux_sel_dm;
  logic             reg_wr_ex;
  logic [RA_W-1:0]  rd_ex;
  logic             zero_ex;
  logic             carry_ex;
  logic             ovf_ex;

  modport master (
    output valid_in, alu_op, op_a, op_b, store_data_in,
           mem_en_in, mem_rw_in, mem_mux_sel_in, reg_wr_in, rd_in,
    input  stall_out, ans_ex, DM_data, mem_en_ex, mem_rw_ex,
           mem_mux_sel_dm, reg_wr_ex, rd_ex, zero_ex, carry_ex, ovf_ex
  );

  modport slave (
    input  valid_in, alu_op, op_a, op_b, store_data_in,
           mem_en_in, mem_rw_in, mem_mux_sel_in, reg_wr_in, rd_in,
    output stall_out, ans_ex, DM_data, mem_en_ex, mem_rw_ex,
           mem_mux_sel_dm, reg_wr_ex, rd_ex, zero_ex, carry_ex, ovf_ex
  );
endinterface

// File: rtl/execute_stage_iter_mult.sv
// rtl/execute_stage_iter_mult.sv - iterative shift-add unsigned multiplier, one bit per cycle
module iter_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mult,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  import ex_pkg::*;

  localparam int CNT_W = $clog2(MUL_ITER);

  mul_state_t         r_state;
  mul_state_t         w_next;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mult;
  logic [CNT_W-1:0]   r_count;
  logic               w_last;

  assign w_last    = (r_count == CNT_W'(MUL_ITER - 1));
  assign o_product = r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_BUSY;
      ST_BUSY: begin
        o_busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands are captured only on the accept edge, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mult  <= '0;
      r_count <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_mcand <= {{WIDTH{1'b0}}, i_mcand};
      r_acc   <= '0;
      r_mult  <= i_mult;
      r_count <= '0;
    end else if (r_state == ST_BUSY) begin
      if (r_mult[0]) r_acc <= r_acc + r_mcand;
      r_mcand <= r_mcand << 1;
      r_mult  <= r_mult >> 1;
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: single-cycle ALU, iterative multiply with HI register, registered outputs
module execute_stage #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic          clk,
  input  logic          reset,
  execute_stage_if.slave bus
);
  import ex_pkg::*;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [3:0]         w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_mul_req;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_idle;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_ans;
  logic [WIDTH-1:0]   r_dm;
  logic               r_mem_en;
  logic               r_mem_rw;
  logic               r_mux;
  logic               r_reg_wr;
  logic [RA_W-1:0]    r_rd;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  assign w_a       = bus.op_a;
  assign w_b       = bus.op_b;
  assign w_sh      = w_b[3:0];
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff    = {1'b0, w_a} - {1'b0, w_b};
  assign w_mul_req = bus.valid_in && (bus.alu_op == ALU_MUL);
  assign w_idle    = !w_mul_busy && !w_mul_done;

  assign bus.stall_out = (w_idle && w_mul_req) || w_mul_busy;

  iter_mult #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_req),
    .i_mcand   (w_a),
    .i_mult    (w_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // w_diff[WIDTH] is the borrow, so carry for SUB is its complement.
  always_comb begin
    w_res   = w_b;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = !w_diff[WIDTH];
        w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      ALU_NOR:  w_res = ~(w_a | w_b);
      ALU_SLL:  w_res = w_a << w_sh;
      ALU_SRL:  w_res = w_a >> w_sh;
      ALU_SRA:  w_res = $unsigned($signed(w_a) >>> w_sh);
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_MFHI: w_res = r_hi;
      default:  w_res = w_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_ans    <= '0;
      r_dm     <= '0;
      r_mem_en <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mux    <= 1'b0;
      r_reg_wr <= 1'b0;
      r_rd     <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_mul_done) begin
      r_hi     <= w_product[2*WIDTH-1:WIDTH];
      r_ans    <= w_product[WIDTH-1:0];
      r_dm     <= bus.store_data_in;
      r_mem_en <= bus.mem_en_in;
      r_mem_rw <= bus.mem_rw_in;
      r_mux    <= bus.mem_mux_sel_in;
      r_reg_wr <= bus.reg_wr_in;
      r_rd     <= bus.rd_in;
      r_zero   <= (w_product[WIDTH-1:0] == '0);
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_idle && bus.valid_in && !w_mul_req) begin
      r_ans    <= w_res;
      r_dm     <= bus.store_data_in;
      r_mem_en <= bus.mem_en_in;
      r_mem_rw <= bus.mem_rw_in;
      r_mux    <= bus.mem_mux_sel_in;
      r_reg_wr <= bus.reg_wr_in;
      r_rd     <= bus.rd_in;
      r_zero   <= (w_res == '0);
      r_carry  <= w_carry;
      r_ovf    <= w_ovf;
    end else begin
      r_ans    <= '0;
      r_dm     <= '0;
      r_mem_en <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mux    <= 1'b0;
      r_reg_wr <= 1'b0;
      r_rd     <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end
  end

  assign bus.ans_ex         = r_ans;
  assign bus.DM_data        = r_dm;
  assign bus.mem_en_ex      = r_mem_en;
  assign bus.mem_rw_ex      = r_mem_rw;
  assign bus.mem_mux_sel_dm = r_mux;
  assign bus.reg_wr_ex      = r_reg_wr;
  assign bus.rd_ex          = r_rd;
  assign bus.zero_ex        = r_zero;
  assign bus.carry_ex       = r_carry;
  assign bus.ovf_ex         = r_ovf;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed bench for execute_stage with an arithmetic reference model
module tb_execute_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  execute_stage_if #(.WIDTH(16), .RA_W(3)) bus();

  execute_stage #(.WIDTH(16), .RA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs after each edge
  logic [15:0] e_ans, e_dm, m_hi;
  logic        e_en, e_rw, e_mux, e_wr, e_zero, e_carry, e_ovf;
  logic [2:0]  e_rd;
  logic [31:0] m_prod;
  int          m_rem = 0;
  bit          m_started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] hi, output logic [15:0] r, output logic c,
                           output logic v);
    int ia, ib, sa, sb, s, p;
    logic signed [15:0] ta, tb;
    ta = a; tb = b;
    ia = a; ib = b; sa = ta; sb = tb;
    p = 1 << b[3:0];
    c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin s = sa + sb; r = 16'(ia + ib); c = (ia + ib) > 65535; v = (s > 32767) || (s < -32768); end
      ALU_SUB: begin s = sa - sb; r = 16'(ia - ib); c = (ia >= ib); v = (s > 32767) || (s < -32768); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLL:  r = 16'(ia * p);
      ALU_SRL:  r = 16'(ia / p);
      ALU_SRA:  r = 16'(ia / p) | (a[15] ? ~16'(65535 / p) : 16'h0000);
      ALU_SLT:  r = (sa < sb) ? 16'd1 : 16'd0;
      ALU_MFHI: r = hi;
      default:  r = b;
    endcase
  endtask

  task automatic bubble();
    e_ans = 0; e_dm = 0; e_en = 0; e_rw = 0; e_mux = 0; e_wr = 0; e_rd = 0;
    e_zero = 0; e_carry = 0; e_ovf = 0;
  endtask

  task automatic load_ctrl();
    e_dm = bus.store_data_in; e_en = bus.mem_en_in; e_rw = bus.mem_rw_in;
    e_mux = bus.mem_mux_sel_in; e_wr = bus.reg_wr_in; e_rd = bus.rd_in;
  endtask

  // m_rem counts edges left until the product lands: 16 busy edges then the done edge.
  always @(posedge clk) begin
    logic [15:0] r;
    logic c, v;
    m_started = 1;
    if (reset) begin
      bubble(); m_hi = 0; m_rem = 0;
    end else if (m_rem >= 2) begin
      bubble(); m_rem--;
    end else if (m_rem == 1) begin
      load_ctrl();
      e_ans = m_prod[15:0]; e_zero = (m_prod[15:0] == 0); e_carry = 0; e_ovf = 0;
      m_hi = m_prod[31:16]; m_rem = 0;
    end else if (bus.valid_in && bus.alu_op == ALU_MUL) begin
      m_prod = 32'(bus.op_a) * 32'(bus.op_b);
      m_rem = 17;
      bubble();
    end else if (bus.valid_in) begin
      model_alu(bus.alu_op, bus.op_a, bus.op_b, m_hi, r, c, v);
      load_ctrl();
      e_ans = r; e_zero = (r == 0); e_carry = c; e_ovf = v;
    end else begin
      bubble();
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("ans_ex", bus.ans_ex, e_ans);
      check("DM_data", bus.DM_data, e_dm);
      check("mem_en_ex", bus.mem_en_ex, e_en);
      check("mem_rw_ex", bus.mem_rw_ex, e_rw);
      check("mem_mux_sel_dm", bus.mem_mux_sel_dm, e_mux);
      check("reg_wr_ex", bus.reg_wr_ex, e_wr);
      check("rd_ex", bus.rd_ex, e_rd);
      check("zero_ex", bus.zero_ex, e_zero);
      check("carry_ex", bus.carry_ex, e_carry);
      check("ovf_ex", bus.ovf_ex, e_ovf);
      check("stall_out", bus.stall_out,
            (m_rem >= 2) || (m_rem == 0 && bus.valid_in && bus.alu_op == ALU_MUL));
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] sd, input logic en,
                       input logic rw, input logic mux, input logic wr, input logic [2:0] rd);
    bus.valid_in = v; bus.alu_op = op; bus.op_a = a; bus.op_b = b;
    bus.store_data_in = sd; bus.mem_en_in = en; bus.mem_rw_in = rw;
    bus.mem_mux_sel_in = mux; bus.reg_wr_in = wr; bus.rd_in = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stall(input string name, output int cnt);
    cnt = 0;
    #1;
    while (bus.stall_out === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
      if (cnt == 5) begin
        check({name, "_busy_ans"}, bus.ans_ex, 16'h0000);
        check({name, "_busy_wr"}, bus.reg_wr_ex, 1'b0);
      end
    end
    check({name, "_stall_cycles"}, cnt, 17);
  endtask

  initial begin
    int cnt;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    drive(1, ALU_ADD, 16'h0001, 16'h0002, 16'h1111, 1, 1, 1, 1, 3'd3);
    tick(); tick();
    check("rst_ans", bus.ans_ex, 16'h0000);
    check("rst_dm", bus.DM_data, 16'h0000);
    check("rst_wr", bus.reg_wr_ex, 1'b0);
    check("rst_stall", bus.stall_out, 1'b0);
    reset = 1'b0;
    drive(1, ALU_MFHI, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 3'd1);
    tick();
    check("rst_hi", bus.ans_ex, 16'h0000);

    drive(1, ALU_ADD, 16'h7FFF, 16'h0001, 16'h0, 0, 0, 0, 1, 3'd1);
    tick();
    check("add_ans", bus.ans_ex, 16'h8000);
    check("add_ovf", bus.ovf_ex, 1'b1);
    check("add_carry", bus.carry_ex, 1'b0);
    check("add_zero", bus.zero_ex, 1'b0);

    drive(1, ALU_SUB, 16'h0005, 16'h0005, 16'h0, 0, 0, 0, 1, 3'd2);
    tick();
    check("sub_ans", bus.ans_ex, 16'h0000);
    check("sub_zero", bus.zero_ex, 1'b1);
    check("sub_carry", bus.carry_ex, 1'b1);

    drive(1, ALU_SRA, 16'h8000, 16'h0004, 16'h0, 0, 0, 0, 1, 3'd3);
    tick();
    check("sra_ans", bus.ans_ex, 16'hF800);

    drive(1, ALU_SLT, 16'h8000, 16'h0001, 16'h0, 0, 0, 0, 1, 3'd3);
    tick();
    check("slt_ans", bus.ans_ex, 16'h0001);

    drive(1, ALU_ADD, 16'h0010, 16'h0004, 16'hBEEF, 1, 1, 0, 0, 3'd0);
    tick();
    check("st_addr", bus.ans_ex, 16'h0014);
    check("st_data", bus.DM_data, 16'hBEEF);
    check("st_en", bus.mem_en_ex, 1'b1);
    check("st_rw", bus.mem_rw_ex, 1'b1);
    check("st_wr", bus.reg_wr_ex, 1'b0);

    for (int op = 0; op < 16; op++) begin
      if (op != 10) begin
        drive(1, 4'(op), 16'hA5C3, 16'h0F10 + 16'(op * 3), 16'(op), op[0], 0, op[1], 1, 3'(op));
        tick();
      end
    end
    drive(1, ALU_SLL, 16'h1234, 16'h0000, 16'h0, 0, 0, 0, 1, 3'd4);
    tick();
    drive(1, ALU_SUB, 16'h0003, 16'h0005, 16'h0, 0, 0, 0, 1, 3'd4);
    tick();
    drive(1, ALU_SUB, 16'h8000, 16'h0001, 16'h0, 0, 0, 0, 1, 3'd4);
    tick();
    drive(1, ALU_ADD, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 0, 1, 3'd4);
    tick();
    drive(0, ALU_ADD, 16'h1234, 16'h1111, 16'h5555, 1, 1, 1, 1, 3'd7);
    tick();

    drive(1, ALU_MUL, 16'h1234, 16'h5678, 16'h0, 0, 0, 0, 1, 3'd5);
    wait_stall("mul1", cnt);
    tick();
    check("mul1_lo", bus.ans_ex, 16'h0060);
    check("mul1_wr", bus.reg_wr_ex, 1'b1);
    drive(1, ALU_MFHI, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 3'd6);
    tick();
    check("mfhi1", bus.ans_ex, 16'h0626);

    drive(1, ALU_MUL, 16'h1234, 16'h5678, 16'h0, 0, 0, 0, 1, 3'd5);
    tick();
    repeat (6) tick();
    reset = 1'b1;
    drive(0, ALU_ADD, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 3'd0);
    tick();
    reset = 1'b0;
    check("mrst_stall", bus.stall_out, 1'b0);
    check("mrst_ans", bus.ans_ex, 16'h0000);
    check("mrst_wr", bus.reg_wr_ex, 1'b0);
    drive(1, ALU_MFHI, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 3'd1);
    tick();
    check("mrst_hi", bus.ans_ex, 16'h0000);

    drive(1, ALU_MUL, 16'h0003, 16'h0004, 16'h0, 0, 0, 0, 1, 3'd2);
    wait_stall("mul2", cnt);
    tick();
    check("mul2_lo", bus.ans_ex, 16'd12);
    drive(1, ALU_MFHI, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 3'd1);
    tick();
    check("mfhi2", bus.ans_ex, 16'h0000);
    drive(0, ALU_ADD, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 3'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 16-bit MIPS pipeline; sits directly upstream of data_memory_Module and drives its ans_ex, DM_data, mem_rw_ex and mem_en_ex inputs, plus the mem-mux select.
- Performs single-cycle ALU operations and a multi-cycle iterative 16x16 multiply. Holds the product high half in a HI register.
- Stalls the decode stage while the multiply runs.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported.
- RA_W, 3, destination register address width.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  decode stage presents a valid instruction.
- alu_op  in  4  operation code (encoding in package).
- op_a  in  16  operand A (rs value or base address).
- op_b  in  16  operand B (rt value or sign-extended immediate).
- store_data_in  in  16  rt value for stores.
- mem_en_in, mem_rw_in, mem_mux_sel_in  in  1 each  memory controls from decode.
- reg_wr_in  in  1  instruction writes the register file.
- rd_in  in  RA_W  destination register.
- stall_out  out  1  decode must hold its outputs this cycle.
- ans_ex  out  16  registered ALU result or memory address.
- DM_data  out  16  registered store data.
- mem_en_ex, mem_rw_ex, mem_mux_sel_dm, reg_wr_ex  out  1 each  registered controls.
- rd_ex  out  RA_W  registered destination.
- zero_ex, carry_ex, ovf_ex  out  1 each  registered flags.

Behaviour:
- Reset: registered outputs go to 0; HI goes to 0; FSM goes to IDLE; any multiply in progress is abandoned with no output. Reset takes precedence over every other event on the same edge.
- Operations, op_b[3:0] used as the shift amount:
  - 0 ADD: result = a+b.
  - 1 SUB: result = a-b.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA.
  - 9 SLT: signed compare, result is 1 or 0.
  - 10 MUL.
  - 11 MFHI: result = HI.
  - 12 PASSB: result = b.
  - 13-15: treated as PASSB.
- Flags:
  - carry: bit 16 of the 17-bit sum for ADD; NOT borrow for SUB.
  - ovf: signed overflow for ADD and SUB.
  - Both are 0 for all other operations.
  - zero: (result == 0) for every operation.
- Single-cycle operations: when the FSM is in IDLE and valid_in=1, the output registers load the result and the pass-through controls at the next edge. Latency is 1 cycle.
- Bubble: when the FSM is in IDLE and valid_in=0, the next edge loads a bubble. A bubble means mem_en_ex=0, mem_rw_ex=0, reg_wr_ex=0, mem_mux_sel_dm=0 and all flags 0; ans_ex and DM_data are don't-care and are driven 0.
- FSM IDLE:
  - If valid_in=1 and alu_op=MUL, the edge loads the multiplicand (a zero-extended to 32 bits), the multiplier (b), a 32-bit accumulator set to 0 and count set to 0, then moves to BUSY.
  - The output registers take a bubble on that edge.
- FSM BUSY:
  - Each edge: if mult[0]=1, acc += mcand; then mcand <<= 1, mult >>= 1, count++.
  - The edge with count==15 performs the last iteration and moves to DONE.
  - The output registers take a bubble on every BUSY edge.
- FSM DONE:
  - The edge loads ans_ex = acc[15:0], zero = (acc[15:0]==0), carry = ovf = 0, and the held controls from the inputs.
  - The same edge writes HI = acc[31:16] and returns to IDLE.
- stall_out (combinational): 1 when (IDLE and valid_in and alu_op==MUL) or in BUSY; otherwise 0.
  - stall_out is 0 in DONE, so decode advances after the DONE edge.
  - Total MUL occupancy: 1 IDLE-accept cycle + 16 BUSY cycles + 1 DONE cycle = 18 cycles. The result appears at the outputs after the 18th edge.
- Inputs during a multiply: decode holds every input stable while stall_out=1. The block samples controls only in IDLE and DONE. Changing op_a/op_b during BUSY has no effect.
- MFHI immediately after MUL returns the new HI, because HI is written on the DONE edge, before MFHI can be accepted.
- Arithmetic:
  - Unsigned multiply; the low half is identical for signed operands.
  - Shifts by 0 pass the value unchanged; SRA replicates bit 15.
- Memory operations: decode issues ADD with base and offset; ans_ex is the address and DM_data = store_data_in, registered on the same edge.

Decomposition:
- Package ex_pkg holds:
  - the alu_op localparams (ADD…PASSB);
  - the FSM state encoding (IDLE=0, BUSY=1, DONE=2);
  - MUL_ITER=16.
- Sub-module iter_mult handles the shift-add multiply with start/busy/done and a 32-bit product. The ALU is combinational logic inside execute_stage.

Test Plan:
- Reset: reset=1 for 2 edges with valid_in=1 and ADD. Every output is 0 and stall_out=0; HI=0.
- ADD: 0x7FFF+0x0001. One edge later ans_ex=0x8000, ovf_ex=1, carry_ex=0, zero_ex=0.
- SUB: 5-5 gives ans_ex=0, zero_ex=1, carry_ex=1.
- SRA: 0x8000 by 4 gives 0xF800.
- Store: mem_en_in=1, mem_rw_in=1, ADD 0x0010+0x0004, store_data_in=0xBEEF. Next edge ans_ex=0x0014, DM_data=0xBEEF, mem_en_ex=1, mem_rw_ex=1, reg_wr_ex=0.
- MUL then MFHI: MUL 0x1234*0x5678.
  - stall_out stays high for exactly 17 cycles.
  - After the 18th edge ans_ex=0x0060 and reg_wr_ex=1.
  - The following MFHI gives ans_ex=0x0626 one edge later.
  - Bubbles appear at the outputs during BUSY.
- Reset mid-multiply: assert reset on BUSY cycle 7. Next edge: state IDLE, stall_out=0, all outputs 0, HI=0. A subsequent MUL 3*4 yields ans_ex=12.
